// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a small first-word fall-through receive FIFO.
// Sticky overrun and framing flags are cleared by clr_err.
module uart_rx_fifo #(
   parameter int unsigned CLKS_PER_BIT = 289,
   parameter int unsigned DEPTH        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       rd_en,
   input  logic       clr_err,
   output logic [7:0] rd_data,
   output logic       rd_valid,
   output logic       overrun,
   output logic       frame_err,
   output logic       busy
);

   localparam int unsigned CNT_W = 10;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_F = PTR_W + 1;
   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_IDLE
   } state_t;

   state_t           state, state_nxt;
   logic             rx_meta, rxs;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [7:0]       shift, shift_nxt;
   logic [2:0]       bit_idx, bit_nxt;
   logic             push_c, ferr_c;

   logic [7:0]       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
   logic [CNT_F-1:0] count, count_nxt;
   logic             full_c, pop_c, wr_c;
   logic [7:0]       head_nxt;

   // Two-flop synchronizer; idles high so reset never looks like a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:      if (!rxs) state_nxt = S_START;
         S_START:     if (cnt == '0) state_nxt = rxs ? S_IDLE : S_DATA;
         S_DATA:      if (cnt == '0 && bit_idx == 3'd7) state_nxt = S_STOP;
         S_STOP:      if (cnt == '0) state_nxt = rxs ? S_IDLE : S_WAIT_IDLE;
         S_WAIT_IDLE: if (rxs) state_nxt = S_IDLE;
         default:     state_nxt = S_IDLE;
      endcase
   end

   // Bit timer, deserializer and push/error strobes.
   always_comb begin
      cnt_nxt   = cnt;
      shift_nxt = shift;
      bit_nxt   = bit_idx;
      push_c    = 1'b0;
      ferr_c    = 1'b0;
      case (state)
         S_IDLE: if (!rxs) cnt_nxt = HALF_LOAD;
         S_START: begin
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else if (!rxs) begin
               cnt_nxt = BIT_LOAD;
               bit_nxt = 3'd0;
            end
         end
         S_DATA: begin
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else begin
               shift_nxt = {rxs, shift[7:1]};
               cnt_nxt   = BIT_LOAD;
               bit_nxt   = bit_idx + 3'd1;
            end
         end
         S_STOP: begin
            if (cnt != '0) cnt_nxt = cnt - CNT_W'(1);
            else if (rxs)  push_c = 1'b1;
            else           ferr_c = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt     <= '0;
         shift   <= '0;
         bit_idx <= '0;
      end else begin
         cnt     <= cnt_nxt;
         shift   <= shift_nxt;
         bit_idx <= bit_nxt;
      end
   end

   // FIFO control; the head byte is precomputed so rd_data is a flop.
   always_comb begin
      full_c     = (count == CNT_F'(DEPTH));
      pop_c      = rd_en && (count != '0);
      wr_c       = push_c && (!full_c || pop_c);
      rd_ptr_nxt = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
      count_nxt  = CNT_F'(count + CNT_F'(wr_c) - CNT_F'(pop_c));
      head_nxt   = 8'h00;
      if (count_nxt != '0) begin
         if (wr_c && rd_ptr_nxt == wr_ptr) head_nxt = shift;
         else                              head_nxt = mem[rd_ptr_nxt];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         rd_valid  <= 1'b0;
         rd_data   <= 8'h00;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
      end else begin
         if (wr_c) begin
            mem[wr_ptr] <= shift;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         rd_ptr    <= rd_ptr_nxt;
         count     <= count_nxt;
         rd_valid  <= (count_nxt != '0);
         rd_data   <= head_nxt;
         overrun   <= (overrun & ~clr_err) | (push_c & full_c & ~pop_c);
         frame_err <= (frame_err & ~clr_err) | ferr_c;
         busy      <= (state_nxt != S_IDLE);
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: per-cycle queue model plus directed frame scenarios.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int DEPTH = 4;
   localparam int FRAME = 10 * CPB;
   // Stop-bit sample edge follows the negedge at this frame cycle index.
   localparam int PUSH_C = 154;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rxd = 1'b1;
   logic       rd_en = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rd_data;
   logic       rd_valid, overrun, frame_err, busy;

   uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .rxd(rxd), .rd_en(rd_en), .clr_err(clr_err),
      .rd_data(rd_data), .rd_valid(rd_valid), .overrun(overrun),
      .frame_err(frame_err), .busy(busy)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] q[$];
   logic       m_ovr = 1'b0;
   logic       m_ferr = 1'b0;
   logic       cap_pre, cap_valid, cap_ferr;
   logic [7:0] cap_data;

   typedef struct {
      logic       re;
      logic       clr;
      logic       exp_v;
      logic [7:0] exp_d;
      logic       exp_ovr;
   } vec_t;
   vec_t tbl[9];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Compare outputs with the model, drive one cycle of inputs, advance model.
   task automatic step(input logic rx, input logic re, input logic clr,
                       input logic push_ev, input logic [7:0] pb, input logic ferr_ev);
      logic pop_ok, full, do_push, ovr_set;
      check("rd_valid", 8'(rd_valid), 8'(q.size() > 0));
      check("rd_data", rd_data, (q.size() > 0) ? q[0] : 8'h00);
      check("overrun", 8'(overrun), 8'(m_ovr));
      check("frame_err", 8'(frame_err), 8'(m_ferr));
      rxd = rx;
      rd_en = re;
      clr_err = clr;
      pop_ok  = re && (q.size() > 0);
      full    = (q.size() == DEPTH);
      do_push = push_ev && (!full || pop_ok);
      ovr_set = push_ev && full && !pop_ok;
      if (pop_ok) void'(q.pop_front());
      if (do_push) q.push_back(pb);
      m_ovr  = ovr_set | (m_ovr & ~clr);
      m_ferr = ferr_ev | (m_ferr & ~clr);
      @(negedge clk);
   endtask

   task automatic idle(input int n, input logic re);
      for (int i = 0; i < n; i++) step(1'b1, re, 1'b0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int hold_low,
                             input int gap, input int pop_at, input int clr_at, input logic rnd);
      logic rx, re, clr;
      for (int c = 0; c < FRAME + hold_low + gap; c++) begin
         if (c < CPB)                     rx = 1'b0;
         else if (c < 9 * CPB)            rx = d[(c - CPB) / CPB];
         else if (c < FRAME)              rx = stop_ok;
         else if (c < FRAME + hold_low)   rx = 1'b0;
         else                             rx = 1'b1;
         re  = (c == pop_at) || (rnd && $urandom_range(0, 7) == 0);
         clr = (c == clr_at) || (rnd && $urandom_range(0, 63) == 0);
         if (c == PUSH_C) cap_pre = rd_valid;
         if (c == PUSH_C + 1) begin
            cap_valid = rd_valid;
            cap_data  = rd_data;
            cap_ferr  = frame_err;
         end
         step(rx, re, clr, (c == PUSH_C) && stop_ok, d, (c == PUSH_C) && !stop_ok);
      end
   endtask

   initial begin
      logic [7:0] exp_pops[4];
      tbl[0] = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1};
      tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h01, 1'b1};
      tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h02, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h03, 1'b1};
      tbl[4] = '{1'b1, 1'b0, 1'b1, 8'h04, 1'b1};
      tbl[5] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1};
      tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      tbl[7] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
      tbl[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0};

      #2 reset = 1'b0;
      @(negedge clk);
      check("rst_valid", 8'(rd_valid), 8'h00);
      check("rst_data", rd_data, 8'h00);
      check("rst_ovr", 8'(overrun), 8'h00);
      check("rst_ferr", 8'(frame_err), 8'h00);
      check("rst_busy", 8'(busy), 8'h00);
      @(negedge clk);
      reset = 1'b1;
      idle(5, 1'b0);

      // Single frame, exact fall-through timing, then pop
      send_frame(8'hA5, 1'b1, 0, 4, -1, -1, 1'b0);
      check("a5_pre_valid", 8'(cap_pre), 8'h00);
      check("a5_valid", 8'(cap_valid), 8'h01);
      check("a5_data", cap_data, 8'hA5);
      step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      check("a5_pop_valid", 8'(rd_valid), 8'h00);
      check("a5_pop_data", rd_data, 8'h00);

      // Five-cycle low glitch
      for (int c = 0; c < 30; c++) begin
         if (c == 6)  check("glitch_busy_hi", 8'(busy), 8'h01);
         if (c == 25) check("glitch_busy_lo", 8'(busy), 8'h00);
         step((c < 5) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      end

      // Back-to-back frames into a full FIFO, then table-driven drain
      for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, (i == 5) ? 4 : 0, -1, -1, 1'b0);
      for (int i = 0; i < 9; i++) begin
         check("tbl_valid", 8'(rd_valid), 8'(tbl[i].exp_v));
         check("tbl_data", rd_data, tbl[i].exp_d);
         check("tbl_ovr", 8'(overrun), 8'(tbl[i].exp_ovr));
         step(1'b1, tbl[i].re, tbl[i].clr, 1'b0, 8'h00, 1'b0);
      end

      // Bad stop bit followed by a long break, flag cleared mid-break
      send_frame(8'h3C, 1'b0, 40 * CPB, 6, -1, 400, 1'b0);
      check("brk_ferr", 8'(cap_ferr), 8'h01);
      check("brk_valid", 8'(cap_valid), 8'h00);
      check("brk_ferr_after", 8'(frame_err), 8'h00);
      send_frame(8'h55, 1'b1, 0, 4, -1, -1, 1'b0);
      check("brk_next_data", rd_data, 8'h55);
      idle(1, 1'b1);
      check("brk_empty", 8'(rd_valid), 8'h00);

      // Push and pop on the same cycle while full
      send_frame(8'h11, 1'b1, 0, 0, -1, -1, 1'b0);
      send_frame(8'h22, 1'b1, 0, 0, -1, -1, 1'b0);
      send_frame(8'h33, 1'b1, 0, 0, -1, -1, 1'b0);
      send_frame(8'h44, 1'b1, 0, 0, -1, -1, 1'b0);
      send_frame(8'h77, 1'b1, 0, 4, PUSH_C, -1, 1'b0);
      check("full_pp_ovr", 8'(overrun), 8'h00);
      exp_pops[0] = 8'h22; exp_pops[1] = 8'h33; exp_pops[2] = 8'h44; exp_pops[3] = 8'h77;
      for (int i = 0; i < 4; i++) begin
         check("full_pp_data", rd_data, exp_pops[i]);
         step(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      end
      check("full_pp_empty", 8'(rd_valid), 8'h00);

      // Reset in the middle of the 4th data bit
      send_frame(8'h99, 1'b1, 0, 4, -1, -1, 1'b0);
      for (int c = 0; c < 70; c++) begin
         logic [7:0] d5a;
         d5a = 8'h5A;
         step((c < CPB) ? 1'b0 : d5a[(c - CPB) / CPB], 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      end
      reset = 1'b0;
      rxd = 1'b1;
      #1;
      check("mid_rst_valid", 8'(rd_valid), 8'h00);
      check("mid_rst_data", rd_data, 8'h00);
      check("mid_rst_busy", 8'(busy), 8'h00);
      q.delete();
      m_ovr = 1'b0;
      m_ferr = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      idle(5, 1'b0);
      check("post_rst_busy", 8'(busy), 8'h00);
      send_frame(8'h81, 1'b1, 0, 4, -1, -1, 1'b0);
      check("post_rst_data", rd_data, 8'h81);
      idle(1, 1'b1);
      check("post_rst_empty", 8'(rd_valid), 8'h00);

      // Randomized traffic against the queue model
      for (int i = 0; i < 40; i++)
         send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 9) != 0),
                    0, $urandom_range(4, 20), -1, -1, 1'b1);
      idle(10, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
